// File: rtl/cam_lru_multi_if.sv
// rtl/cam_lru_multi_if.sv - request/response bundle for cam_lru_multi
interface cam_lru_multi_if #(
    parameter int key_width_p = 16,
    parameter int val_width_p = 16
);
    logic                   valid_i;
    logic [1:0]             op_i;
    logic [key_width_p-1:0] key_i;
    logic [val_width_p-1:0] val_i;
    logic                   valid_o;
    logic                   hit_o;
    logic [val_width_p-1:0] val_o;
    logic                   evict_o;
    logic [key_width_p-1:0] evict_key_o;
    logic [val_width_p-1:0] evict_val_o;

    modport master (
        output valid_i, op_i, key_i, val_i,
        input  valid_o, hit_o, val_o, evict_o, evict_key_o, evict_val_o
    );

    modport slave (
        input  valid_i, op_i, key_i, val_i,
        output valid_o, hit_o, val_o, evict_o, evict_key_o, evict_val_o
    );
endinterface

// File: rtl/cam_lru_multi.sv
// rtl/cam_lru_multi.sv - fully-associative true-LRU key/value CAM; CAM_EVICT_REPORT_EN enables eviction reporting
module cam_lru_multi #(
    parameter int key_width_p = 16,
    parameter int val_width_p = 16,
    parameter int camsize_p   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    cam_lru_multi_if.slave    cam
);
    localparam int idx_w_lp = (camsize_p > 1) ? $clog2(camsize_p) : 1;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_INVAL = 2'd2;
    localparam logic [1:0] OP_FLUSH = 2'd3;

    localparam logic [idx_w_lp-1:0] RANK_LRU = idx_w_lp'(camsize_p - 1);

    // Entry storage; rank 0 is most recently used, ranks stay a permutation
    logic [camsize_p-1:0]   r_valid;
    logic [key_width_p-1:0] r_key  [camsize_p];
    logic [val_width_p-1:0] r_val  [camsize_p];
    logic [idx_w_lp-1:0]    r_rank [camsize_p];

    // Registered read response
    logic                   r_valid_o;
    logic                   r_hit_o;
    logic [val_width_p-1:0] r_val_o;

    logic [camsize_p-1:0]   w_match;
    logic                   w_hit;
    logic [idx_w_lp-1:0]    w_hit_idx;
    logic                   w_free_any;
    logic [idx_w_lp-1:0]    w_free_idx;
    logic [idx_w_lp-1:0]    w_lru_idx;
    logic [idx_w_lp-1:0]    w_victim_idx;
    logic                   w_req_read;
    logic                   w_req_write;
    logic                   w_promote;
    logic [idx_w_lp-1:0]    w_promote_idx;
    logic [idx_w_lp-1:0]    w_promote_rank;

    // Key compare across all entries; also locate the entry holding the LRU rank
    always_comb begin
        w_match   = '0;
        w_hit_idx = '0;
        w_lru_idx = '0;
        for (int i = 0; i < camsize_p; i++) begin
            w_match[i] = r_valid[i] && (r_key[i] == cam.key_i);
            if (w_match[i]) begin
                w_hit_idx = idx_w_lp'(i);
            end
            if (r_rank[i] == RANK_LRU) begin
                w_lru_idx = idx_w_lp'(i);
            end
        end
    end

    // Lowest-index invalid entry, scanned from the top so the lowest wins
    always_comb begin
        w_free_idx = '0;
        for (int i = camsize_p - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = idx_w_lp'(i);
            end
        end
    end

    assign w_hit          = |w_match;
    assign w_free_any     = ~&r_valid;
    assign w_victim_idx   = w_free_any ? w_free_idx : w_lru_idx;
    assign w_req_read     = cam.valid_i && (cam.op_i == OP_READ);
    assign w_req_write    = cam.valid_i && (cam.op_i == OP_WRITE);
    // Read hits and every write (hit or install) make the touched entry MRU
    assign w_promote      = (w_req_read && w_hit) || w_req_write;
    assign w_promote_idx  = w_hit ? w_hit_idx : w_victim_idx;
    assign w_promote_rank = r_rank[w_promote_idx];

    // LRU rank update: entries more recent than the promoted one age by one
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < camsize_p; i++) begin
                r_rank[i] <= idx_w_lp'(i);
            end
        end else if (w_promote) begin
            for (int i = 0; i < camsize_p; i++) begin
                if (idx_w_lp'(i) == w_promote_idx) begin
                    r_rank[i] <= '0;
                end else if (r_rank[i] < w_promote_rank) begin
                    r_rank[i] <= r_rank[i] + 1'b1;
                end
            end
        end
    end

    // Valid/key/value array update for write, invalidate and flush
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            for (int i = 0; i < camsize_p; i++) begin
                r_key[i] <= '0;
                r_val[i] <= '0;
            end
        end else if (cam.valid_i) begin
            case (cam.op_i)
                OP_WRITE: begin
                    if (w_hit) begin
                        r_val[w_hit_idx] <= cam.val_i;
                    end else begin
                        r_valid[w_victim_idx] <= 1'b1;
                        r_key[w_victim_idx]   <= cam.key_i;
                        r_val[w_victim_idx]   <= cam.val_i;
                    end
                end
                OP_INVAL: begin
                    if (w_hit) begin
                        r_valid[w_hit_idx] <= 1'b0;
                    end
                end
                OP_FLUSH: begin
                    r_valid <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Read response: one-cycle pulse, data forced to zero on a miss
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_o <= 1'b0;
            r_hit_o   <= 1'b0;
            r_val_o   <= '0;
        end else begin
            r_valid_o <= w_req_read;
            r_hit_o   <= w_req_read && w_hit;
            r_val_o   <= (w_req_read && w_hit) ? r_val[w_hit_idx] : '0;
        end
    end

    assign cam.valid_o = r_valid_o;
    assign cam.hit_o   = r_hit_o;
    assign cam.val_o   = r_val_o;

`ifdef CAM_EVICT_REPORT_EN
    logic                   r_evict;
    logic [key_width_p-1:0] r_evict_key;
    logic [val_width_p-1:0] r_evict_val;

    // Capture the displaced entry when a write miss finds no free slot
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_evict     <= 1'b0;
            r_evict_key <= '0;
            r_evict_val <= '0;
        end else if (w_req_write && !w_hit && !w_free_any) begin
            r_evict     <= 1'b1;
            r_evict_key <= r_key[w_lru_idx];
            r_evict_val <= r_val[w_lru_idx];
        end else begin
            r_evict     <= 1'b0;
            r_evict_key <= '0;
            r_evict_val <= '0;
        end
    end

    assign cam.evict_o     = r_evict;
    assign cam.evict_key_o = r_evict_key;
    assign cam.evict_val_o = r_evict_val;
`else
    assign cam.evict_o     = 1'b0;
    assign cam.evict_key_o = '0;
    assign cam.evict_val_o = '0;
`endif

endmodule

// File: tb/tb_cam_lru_multi.sv
// tb/tb_cam_lru_multi.sv - randomized model-checked bench for cam_lru_multi
module tb_cam_lru_multi;
    localparam int KW = 16;
    localparam int VW = 16;
    localparam int N  = 4;

    localparam logic [1:0] RD = 2'd0;
    localparam logic [1:0] WR = 2'd1;
    localparam logic [1:0] IV = 2'd2;
    localparam logic [1:0] FL = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cam_lru_multi_if #(.key_width_p(KW), .val_width_p(VW)) bus ();

    cam_lru_multi #(.key_width_p(KW), .val_width_p(VW), .camsize_p(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .cam   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: MRU-first list of entry indices instead of numeric ranks
    bit          m_v [N];
    logic [KW-1:0] m_k [N];
    logic [VW-1:0] m_d [N];
    int          order[$];
    bit          chk_en = 1'b0;

    logic          e_valid, e_hit, e_ev;
    logic [VW-1:0] e_val, e_evv;
    logic [KW-1:0] e_evk;
    int            h, vic;

    function automatic int m_find(input logic [KW-1:0] k);
        for (int i = 0; i < N; i++) begin
            if (m_v[i] && m_k[i] == k) return i;
        end
        return -1;
    endfunction

    function automatic void m_touch(input int e);
        for (int j = 0; j < order.size(); j++) begin
            if (order[j] == e) begin
                order.delete(j);
                break;
            end
        end
        order.push_front(e);
    endfunction

    always @(posedge clk) begin
        e_valid = 1'b0; e_hit = 1'b0; e_val = '0;
        e_ev = 1'b0; e_evk = '0; e_evv = '0;
        if (rst) begin
            order.delete();
            for (int i = 0; i < N; i++) begin
                m_v[i] = 1'b0; m_k[i] = '0; m_d[i] = '0;
                order.push_back(i);
            end
            chk_en = 1'b1;
        end else if (bus.valid_i) begin
            h = m_find(bus.key_i);
            case (bus.op_i)
                RD: begin
                    e_valid = 1'b1;
                    if (h >= 0) begin
                        e_hit = 1'b1;
                        e_val = m_d[h];
                        m_touch(h);
                    end
                end
                WR: begin
                    if (h >= 0) begin
                        m_d[h] = bus.val_i;
                        m_touch(h);
                    end else begin
                        vic = -1;
                        for (int i = N - 1; i >= 0; i--) if (!m_v[i]) vic = i;
                        if (vic < 0) begin
                            vic = order[order.size() - 1];
`ifdef CAM_EVICT_REPORT_EN
                            e_ev = 1'b1; e_evk = m_k[vic]; e_evv = m_d[vic];
`endif
                        end
                        m_v[vic] = 1'b1; m_k[vic] = bus.key_i; m_d[vic] = bus.val_i;
                        m_touch(vic);
                    end
                end
                IV: if (h >= 0) m_v[h] = 1'b0;
                default: for (int i = 0; i < N; i++) m_v[i] = 1'b0;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_o", 32'(bus.valid_o), 32'(e_valid));
            chk("hit_o", 32'(bus.hit_o), 32'(e_hit));
            chk("val_o", 32'(bus.val_o), 32'(e_val));
            chk("evict_o", 32'(bus.evict_o), 32'(e_ev));
            chk("evict_key_o", 32'(bus.evict_key_o), 32'(e_evk));
            chk("evict_val_o", 32'(bus.evict_val_o), 32'(e_evv));
        end
    end

    task automatic drive(input bit r, input bit v, input logic [1:0] op,
                         input logic [KW-1:0] k, input logic [VW-1:0] d);
        @(negedge clk);
        rst         = r;
        bus.valid_i = v;
        bus.op_i    = op;
        bus.key_i   = k;
        bus.val_i   = d;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_expect(input string name, input logic [KW-1:0] k,
                             input bit hit, input logic [VW-1:0] d);
        drive(0, 1, RD, k, '0);
        settle();
        chk({name, "_valid"}, 32'(bus.valid_o), 32'd1);
        chk({name, "_hit"}, 32'(bus.hit_o), 32'(hit));
        chk({name, "_val"}, 32'(bus.val_o), 32'(d));
    endtask

    task automatic fill4();
        drive(1, 0, RD, '0, '0);
        for (int k = 1; k <= 4; k++) drive(0, 1, WR, KW'(k), VW'(16'h0100 + k));
    endtask

    initial begin
        bus.valid_i = 1'b0; bus.op_i = RD; bus.key_i = '0; bus.val_i = '0;
        drive(1, 0, RD, '0, '0);
        settle();
        chk("reset_valid_o", 32'(bus.valid_o), 32'd0);
        chk("reset_val_o", 32'(bus.val_o), 32'd0);

        rd_expect("miss_after_reset", 16'h0001, 1'b0, 16'h0000);

        drive(0, 1, WR, 16'h0010, 16'hAAAA);
        rd_expect("rd_aaaa", 16'h0010, 1'b1, 16'hAAAA);
        drive(0, 1, WR, 16'h0010, 16'hBBBB);
        rd_expect("rd_bbbb", 16'h0010, 1'b1, 16'hBBBB);
        chk("one_valid", 32'($countones(dut.r_valid)), 32'd1);

        fill4();
        drive(0, 1, RD, 16'd1, '0);
        drive(0, 1, WR, 16'd5, 16'h0105);
        settle();
`ifdef CAM_EVICT_REPORT_EN
        chk("evict_flag", 32'(bus.evict_o), 32'd1);
        chk("evict_key", 32'(bus.evict_key_o), 32'd2);
        chk("evict_val", 32'(bus.evict_val_o), 32'h0102);
`else
        chk("evict_flag", 32'(bus.evict_o), 32'd0);
        chk("evict_key", 32'(bus.evict_key_o), 32'd0);
`endif
        rd_expect("evicted_2", 16'd2, 1'b0, 16'h0000);
        rd_expect("kept_1", 16'd1, 1'b1, 16'h0101);

        fill4();
        drive(0, 1, IV, 16'd3, '0);
        drive(0, 1, WR, 16'd9, 16'h0109);
        settle();
        chk("inval_no_evict", 32'(bus.evict_o), 32'd0);
        chk("slot2_key", 32'(dut.r_key[2]), 32'd9);
        rd_expect("kept_1b", 16'd1, 1'b1, 16'h0101);
        rd_expect("kept_2b", 16'd2, 1'b1, 16'h0102);
        rd_expect("kept_4b", 16'd4, 1'b1, 16'h0104);
        rd_expect("gone_3", 16'd3, 1'b0, 16'h0000);

        drive(0, 1, FL, '0, '0);
        rd_expect("flush_1", 16'd1, 1'b0, 16'h0000);
        rd_expect("flush_2", 16'd2, 1'b0, 16'h0000);
        rd_expect("flush_4", 16'd4, 1'b0, 16'h0000);
        rd_expect("flush_9", 16'd9, 1'b0, 16'h0000);
        drive(0, 1, WR, 16'd7, 16'h0707);
        settle();
        chk("flush_slot0_key", 32'(dut.r_key[0]), 32'd7);
        chk("flush_slot0_valid", 32'(dut.r_valid[0]), 32'd1);

        drive(1, 1, WR, 16'h0020, 16'h1234);
        settle();
        chk("rst_req_valid_o", 32'(bus.valid_o), 32'd0);
        chk("rst_req_hit_o", 32'(bus.hit_o), 32'd0);
        chk("rst_req_val_o", 32'(bus.val_o), 32'd0);
        chk("rst_req_evict_o", 32'(bus.evict_o), 32'd0);
        rd_expect("rst_req_dropped", 16'h0020, 1'b0, 16'h0000);

        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [1:0] op;
            r = $urandom_range(0, 99);
            if (r < 40) op = RD;
            else if (r < 80) op = WR;
            else if (r < 92) op = IV;
            else op = FL;
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) != 0), op,
                  KW'($urandom_range(0, 7)), VW'($urandom));
        end
        drive(0, 0, RD, '0, '0);
        drive(0, 0, RD, '0, '0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
